uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
- Receive-side companion of the DIY UART transmitter. Recovers 8N1 bytes from an asynchronous serial line, for example the transmitter's `serial` pin looped back, or a USB-UART bridge.
- Runs on the 24 MHz main clock with an internal bit-period counter. No separate baud clock.
- Delivers each byte through a valid/ack handshake to downstream logic: string compare, LED display or debug capture.

Parameters:
- CLKS_PER_BIT, 2500, main-clock cycles per bit (24 MHz / 9600 baud). Legal range 4..65535.
- HALF_BIT, CLKS_PER_BIT/2, offset from the start edge to the first sample point. Derived; do not override.

Ports:
- clk  in  1  main clock (24 MHz).
- rst  in  1  asynchronous reset, active-high.
- line  in  1  serial input. Asynchronous; idles high.
- data  out  8  received byte. Held stable while data_valid=1.
- data_valid  out  1  byte available. Stays high until acknowledged.
- data_ack  in  1  consumer accepts the byte. Sampled only while data_valid=1.
- busy  out  1  receiver is inside a frame (any state except IDLE).
- frame_err  out  1  one-cycle pulse: the stop bit was sampled low.
- overrun  out  1  one-cycle pulse: a new byte completed while data_valid=1.

Behaviour:
- Reset values: data=0, data_valid=0, busy=0, frame_err=0, overrun=0, state=IDLE. Synchronizer flops reset to 1 so that reset does not produce a false start.
- Input path: 2-flop synchronizer on `line`, giving `ls`. All decisions use `ls`; the pin-to-`ls` latency is 2 cycles.
- Bit counter:
  - Width $clog2(CLKS_PER_BIT).
  - Loaded with 0 on the start edge.
  - Wraps at CLKS_PER_BIT-1.
  - A sample strobe fires when the counter equals HALF_BIT-1 in START, and CLKS_PER_BIT-1 thereafter.
  - Net effect: sample points lie HALF_BIT + k·CLKS_PER_BIT cycles after the first low `ls`, for k=0 (start), k=1..8 (data bits, LSB first) and k=9 (stop).
- State machine:
  - IDLE: wait for `ls`=0, then go to START and clear the counter.
  - START: at the mid-bit sample:
    - `ls`=1 is a glitch or false start → IDLE, no flags.
    - `ls`=0 → DATA, bit index cleared to 0.
  - DATA: at each sample, shift `ls` into bit[index] and increment the 3-bit index. After bit 7 → STOP.
  - STOP: at the sample:
    - `ls`=1 → deliver the byte, then IDLE. Re-arming at mid-stop supports back-to-back frames.
    - `ls`=0 → frame_err pulse, byte discarded, then BREAK.
  - BREAK: wait until `ls`=1, then IDLE. This prevents a held-low line (break) from producing repeated frames.
- Delivery:
  - On the cycle after the good stop sample: data ← shift register and data_valid ← 1.
  - If data_valid was already 1 at that point: data is overwritten with the new byte, data_valid stays 1, and overrun pulses for one cycle.
- Handshake:
  - data_valid clears on the cycle after data_ack=1 is sampled with data_valid=1.
  - If ack and a new delivery coincide, the delivery wins: data_valid stays 1 with the new data and no overrun pulse.
  - data_ack with data_valid=0 is ignored.
- busy=1 in START, DATA, STOP and BREAK.
- Reset asserted mid-frame returns all outputs to their reset values immediately and discards the partial byte.
- Line activity during reset is ignored. After reset release a frame is recognised only from a fresh high→low edge on `ls`. A line already low at release goes IDLE→START, fails the start check unless it is still low at mid-bit, and proceeds normally if it is.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each sample decision takes the 2-of-3 majority of `ls` at sample-1, sample and sample+1.
  - Sample strobes move one cycle later to use the third sample; all outputs are delayed by 1 cycle relative to the plain build.
  - A single-cycle glitch at a sample point is rejected.
  - Requires CLKS_PER_BIT ≥ 8.
- Undefined: single sample at the strobe, exactly as described in Behaviour.

Test Plan (CLKS_PER_BIT=16 unless noted):
- Single byte: drive 0x41 framed 8N1 at 16 clk/bit → data=0x41 and data_valid=1 within 2+8+9·16+1 cycles of the start edge; frame_err=0. ack → data_valid=0 next cycle.
- Back-to-back: 0x41,0x42,0x43,0x44 with no idle gap, acked promptly → four deliveries in order, no overrun; busy never drops for more than 8 cycles between frames.
- Overrun: send 0x55 then 0xAA without ack → second delivery gives overrun pulse, data=0xAA, data_valid still 1.
- False start / framing: a 4-cycle low glitch → no delivery and busy returns to 0. A frame with stop=0 (0x00 then line held low 40 bit-times) → one frame_err pulse, no data_valid, stays in BREAK until line high, then the next 0x7E is received correctly.
- Reset mid-frame: assert rst during bit 3 of 0x99 → outputs 0 immediately. Release, send 0x3C → data=0x3C with no residue.
- With UART_RX_MAJORITY_EN: 0x41 with a 1-cycle inverted glitch at each mid-bit → data=0x41, received 1 cycle later than the plain build.

Source files
------------

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with an internal bit-period counter and a valid/ack byte output.
// Latency: 2-cycle line synchronizer; byte is visible 1 cycle after the mid-stop sample.
// Backpressure: none on the serial line; an unacknowledged byte is overwritten and overrun pulses.
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling (adds 1 cycle, CLKS_PER_BIT >= 8).
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 2500,
  localparam int HALF_BIT = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  // The vote needs the sample after the nominal point, so every strobe lands one cycle later.
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(HALF_BIT);
`else
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(HALF_BIT - 1);
`endif

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic             sync1;
  logic             ls;
  logic             bit_val;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             strobe;
  logic             deliver;
  logic             stop_bad;

  // Two-flop synchronizer; resets high so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      ls    <= 1'b1;
    end else begin
      sync1 <= line;
      ls    <= sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic ls_d1;
  logic ls_d2;

  // Short history of the synchronized line for the 2-of-3 vote around each sample point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ls_d1 <= 1'b1;
      ls_d2 <= 1'b1;
    end else begin
      ls_d1 <= ls;
      ls_d2 <= ls_d1;
    end
  end

  assign bit_val = (ls & ls_d1) | (ls & ls_d2) | (ls_d1 & ls_d2);
`else
  assign bit_val = ls;
`endif

  // Sample strobe: mid start bit in START, end of each full bit period afterwards.
  always_comb begin
    strobe = 1'b0;
    if (state == ST_START) begin
      strobe = (cnt == CNT_MID);
    end else if (state == ST_DATA || state == ST_STOP) begin
      strobe = (cnt == CNT_LAST);
    end
  end

  assign deliver  = (state == ST_STOP) && strobe && bit_val;
  assign stop_bad = (state == ST_STOP) && strobe && !bit_val;
  assign busy     = (state != ST_IDLE);

  // Frame sequencing: state, bit-period counter, bit index and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      // Counter idles at zero, so entering START starts the bit timing from the edge.
      if (state == ST_IDLE || state == ST_BREAK || strobe) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (!ls) begin
            state <= ST_START;
          end
        end
        ST_START: begin
          if (strobe) begin
            if (bit_val) begin
              // Line back high at mid start bit: glitch, drop silently.
              state <= ST_IDLE;
            end else begin
              state   <= ST_DATA;
              bit_idx <= 3'd0;
            end
          end
        end
        ST_DATA: begin
          if (strobe) begin
            shreg[bit_idx] <= bit_val;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (strobe) begin
            // Re-arm at mid stop bit so a following start edge is not missed.
            state <= bit_val ? ST_IDLE : ST_BREAK;
          end
        end
        ST_BREAK: begin
          // Held-low line must return high before another frame can start.
          if (ls) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output register: byte delivery, valid/ack handshake and single-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (deliver) begin
        // A new byte always wins; it only counts as overrun if the old one was not being taken.
        data       <= shreg;
        data_valid <= 1'b1;
        overrun    <= data_valid && !data_ack;
      end else if (data_valid && data_ack) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte at 16 clocks per bit: reset, table of single frames,
// hand-built corner sequences, then random traffic against a sample-point reference model.
module tb_uart_rx_byte;
  localparam int C = 16;
  localparam int H = C / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif
  // Steps from the first low pin sample to data_valid visible (counting that first step).
  localparam int LAT = 2 + H + 9 * C + 1 + OFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line = 1'b1;
  logic       data_ack = 1'b0;
  logic [7:0] data;
  logic       data_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  uart_rx_byte #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .line(line), .data(data), .data_valid(data_valid),
    .data_ack(data_ack), .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int base = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int last_dv = 0;
  int bl_run = 0;
  int bl_max = 0;
  bit dv_q = 1'b0;
  bit log_en = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] got_r[$];
  int del_t[$];
  int fe_t[$];
  bit wave[$];
  int exp_t[$];
  int exp_fe[$];
  logic [7:0] exp_b[$];

  typedef struct {
    logic [7:0] val;
    bit         stop;
    logic [7:0] exp_data;
    bit         exp_valid;
    bit         exp_ferr;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock; outputs are looked at 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (frame_err === 1'b1) begin
      fe_cnt++;
      if (log_en) fe_t.push_back(cyc - base);
    end
    if (overrun === 1'b1) ov_cnt++;
    if ((data_valid === 1'b1 && !dv_q) || overrun === 1'b1) begin
      dv_cnt++;
      last_dv = cyc;
      got_q.push_back(data);
      if (log_en) begin
        got_r.push_back(data);
        del_t.push_back(cyc - base);
      end
    end
    dv_q = (data_valid === 1'b1);
    if (busy === 1'b1) begin
      if (bl_run > bl_max) bl_max = bl_run;
      bl_run = 0;
    end else begin
      bl_run++;
    end
  endtask

  task automatic hold(input logic v, input int n, input bit ack);
    line = v;
    for (int i = 0; i < n; i++) begin
      if (ack) data_ack = data_valid;
      step();
    end
    data_ack = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input bit ack);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) hold(f[k], C, ack);
  endtask

  function automatic logic [7:0] q_at(input int idx);
    if (idx < got_q.size()) return got_q[idx];
    return 8'hxx;
  endfunction

  // Synchronized line as the receiver sees it at posedge n of the random run.
  function automatic bit lv(input int n);
    if (n < 2 || n - 2 >= wave.size()) return 1'b1;
    return wave[n - 2];
  endfunction

  // Bit decision around a nominal sample point.
  function automatic bit samp(input int c);
`ifdef UART_RX_MAJORITY_EN
    int ones;
    ones = int'(lv(c - 1)) + int'(lv(c)) + int'(lv(c + 1));
    return ones >= 2;
`else
    return lv(c);
`endif
  endfunction

  // Reference: walk the line, sampling at HALF_BIT + k*C after each start edge.
  task automatic run_model();
    int n;
    int c;
    logic [7:0] b;
    n = 0;
    b = 8'h00;
    while (n < wave.size()) begin
      if (lv(n) == 1'b0) begin
        c = n + H;
        if (samp(c)) begin
          n = c + OFF + 1;
        end else begin
          for (int k = 1; k <= 8; k++) b[k-1] = samp(c + k * C);
          c = c + 9 * C;
          n = c + OFF + 1;
          if (samp(c)) begin
            exp_t.push_back(c + OFF);
            exp_b.push_back(b);
          end else begin
            exp_fe.push_back(c + OFF);
            while (lv(n) == 1'b0) n++;
            n++;
          end
        end
      end else begin
        n++;
      end
    end
  endtask

  initial begin : main
    int dv0, fe0, ov0, t0, nq, m;
    logic [7:0] rb;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    check("reset data", data, 0);
    check("reset data_valid", data_valid, 0);
    check("reset busy", busy, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overrun", overrun, 0);
    rst = 1'b0;
    hold(1'b1, 2 * C, 1'b0);

    // Single frames from a table
    vecs[0] = '{8'h41, 1'b1, 8'h41, 1'b1, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 8'hFF, 1'b0, 1'b1};
    vecs[4] = '{8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    for (int v = 0; v < 5; v++) begin
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      t0 = cyc + 1;
      send_frame(vecs[v].val, vecs[v].stop, 1'b0);
      hold(1'b1, 16, 1'b0);
      check($sformatf("vec%0d deliveries", v), dv_cnt - dv0, vecs[v].exp_valid);
      check($sformatf("vec%0d frame_err", v), fe_cnt - fe0, vecs[v].exp_ferr);
      check($sformatf("vec%0d data", v), data, vecs[v].exp_data);
      check($sformatf("vec%0d data_valid", v), data_valid, vecs[v].exp_valid);
      check($sformatf("vec%0d busy", v), busy, 0);
      if (vecs[v].exp_valid) begin
        check($sformatf("vec%0d latency", v), last_dv - t0 + 1, LAT);
        data_ack = 1'b1;
        step();
        data_ack = 1'b0;
        check($sformatf("vec%0d ack clears", v), data_valid, 0);
      end
    end

    // Short low glitch is not a start bit
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    hold(1'b0, 4, 1'b0);
    hold(1'b1, 3 * C, 1'b0);
    check("glitch deliveries", dv_cnt - dv0, 0);
    check("glitch frame_err", fe_cnt - fe0, 0);
    check("glitch busy", busy, 0);

    // Back-to-back frames, acked promptly
    dv0 = dv_cnt;
    ov0 = ov_cnt;
    nq = got_q.size();
    bl_run = 0;
    bl_max = 0;
    for (int k = 0; k < 4; k++) send_frame(8'h41 + 8'(k), 1'b1, 1'b1);
    hold(1'b1, 2 * C, 1'b1);
    check("b2b deliveries", dv_cnt - dv0, 4);
    for (int k = 0; k < 4; k++) check($sformatf("b2b byte%0d", k), q_at(nq + k), 8'h41 + 8'(k));
    check("b2b overrun", ov_cnt - ov0, 0);
    check("b2b busy gap <= 8", bl_max <= 8, 1);

    // Overrun: two bytes without ack
    dv0 = dv_cnt;
    ov0 = ov_cnt;
    send_frame(8'h55, 1'b1, 1'b0);
    hold(1'b1, 4, 1'b0);
    send_frame(8'hAA, 1'b1, 1'b0);
    hold(1'b1, 16, 1'b0);
    check("ovr deliveries", dv_cnt - dv0, 2);
    check("ovr pulse count", ov_cnt - ov0, 1);
    check("ovr data", data, 8'hAA);
    check("ovr data_valid", data_valid, 1);
    data_ack = 1'b1;
    step();
    data_ack = 1'b0;
    check("ovr ack clears", data_valid, 0);

    // Bad stop bit followed by a long break
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h00, 1'b0, 1'b0);
    hold(1'b0, 40 * C, 1'b0);
    check("break frame_err", fe_cnt - fe0, 1);
    check("break deliveries", dv_cnt - dv0, 0);
    check("break busy held", busy, 1);
    hold(1'b1, 2 * C, 1'b0);
    check("break exit busy", busy, 0);
    send_frame(8'h7E, 1'b1, 1'b0);
    hold(1'b1, 16, 1'b0);
    check("after break data", data, 8'h7E);
    check("after break deliveries", dv_cnt - dv0, 1);
    check("after break frame_err", fe_cnt - fe0, 1);

    // Reset in the middle of bit 3 of 0x99 (0x7E still pending)
    hold(1'b0, C, 1'b0);
    hold(1'b1, C, 1'b0);
    hold(1'b0, 2 * C, 1'b0);
    hold(1'b1, H, 1'b0);
    rst = 1'b1;
    #1;
    check("rst data", data, 0);
    check("rst data_valid", data_valid, 0);
    check("rst busy", busy, 0);
    line = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    hold(1'b1, 20, 1'b0);
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b1, 1'b0);
    hold(1'b1, 16, 1'b0);
    check("post-rst data", data, 8'h3C);
    check("post-rst deliveries", dv_cnt - dv0, 1);
    check("post-rst frame_err", fe_cnt - fe0, 0);
    data_ack = 1'b1;
    step();
    data_ack = 1'b0;

`ifdef UART_RX_MAJORITY_EN
    // One-cycle inverted glitch at every mid-bit is voted out
    begin : maj_test
      logic [9:0] f;
      f = {1'b1, 8'h41, 1'b0};
      dv0 = dv_cnt;
      t0 = cyc + 1;
      for (int j = 0; j < 10 * C; j++) begin
        line = (j % C == H) ? ~f[j / C] : f[j / C];
        step();
      end
      hold(1'b1, 16, 1'b0);
      check("maj data", data, 8'h41);
      check("maj deliveries", dv_cnt - dv0, 1);
      check("maj latency", last_dv - t0 + 1, LAT);
      data_ack = 1'b1;
      step();
      data_ack = 1'b0;
    end
`endif

    // Random traffic: gaps, glitches, back-to-back frames, bad stops with breaks
    for (int f = 0; f < 24; f++) begin
      m = $urandom_range(0, 24);
      for (int i = 0; i < m; i++) wave.push_back(1'b1);
      if ($urandom_range(0, 5) == 0) begin
        m = $urandom_range(1, 6);
        for (int i = 0; i < m; i++) wave.push_back(1'b0);
        m = $urandom_range(3, 12);
        for (int i = 0; i < m; i++) wave.push_back(1'b1);
      end
      rb = 8'($urandom);
      for (int i = 0; i < C; i++) wave.push_back(1'b0);
      for (int k = 0; k < 8; k++) for (int i = 0; i < C; i++) wave.push_back(rb[k]);
      if ($urandom_range(0, 7) != 0) begin
        for (int i = 0; i < C; i++) wave.push_back(1'b1);
      end else begin
        m = C + $urandom_range(0, 2 * C);
        for (int i = 0; i < m; i++) wave.push_back(1'b0);
      end
    end
    for (int i = 0; i < 3 * C; i++) wave.push_back(1'b1);
    run_model();

    ov0 = ov_cnt;
    base = cyc + 1;
    log_en = 1'b1;
    for (int i = 0; i < wave.size(); i++) begin
      line = wave[i];
      data_ack = data_valid;
      step();
    end
    data_ack = 1'b0;
    log_en = 1'b0;
    check("rnd delivery count", del_t.size(), exp_t.size());
    for (int i = 0; i < del_t.size() && i < exp_t.size(); i++) begin
      check($sformatf("rnd byte%0d", i), got_r[i], exp_b[i]);
      check($sformatf("rnd time%0d", i), del_t[i], exp_t[i]);
    end
    check("rnd frame_err count", fe_t.size(), exp_fe.size());
    for (int i = 0; i < fe_t.size() && i < exp_fe.size(); i++) begin
      check($sformatf("rnd ferr time%0d", i), fe_t[i], exp_fe[i]);
    end
    check("rnd overrun", ov_cnt - ov0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
